// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - field-level instruction request to 32-bit word builder with auto-incrementing memory write; optional macro ENC_SBIT_FORCE_EN
module instr_encoder #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        op,
    input  logic [5:0]        funct,
    input  logic [3:0]        cond,
    input  logic [3:0]        rn,
    input  logic [3:0]        rd,
    input  logic [11:0]       src2,
    input  logic [ADDR_W-1:0] b_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              err,
    output logic [7:0]        err_cnt,
    output logic              full
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ENCODE = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = '1;
    localparam int OFF_W = ADDR_W + 2;

    logic [1:0]        state;
    logic [1:0]        op_q;
    logic [5:0]        funct_q;
    logic [3:0]        cond_q;
    logic [3:0]        rn_q;
    logic [3:0]        rd_q;
    logic [11:0]       src2_q;
    logic [ADDR_W-1:0] b_target_q;

    logic [3:0]        cmd;
    logic              legal;
    logic [5:0]        funct_enc;
    logic [OFF_W-1:0]  br_off;
    logic [23:0]       imm24;
    logic [31:0]       word;

    // Legality check and word build from the registered request
    always_comb begin
        cmd       = funct_q[4:1];
        funct_enc = funct_q;
        legal     = 1'b0;
        // Branch offset is relative to PC+8, i.e. the write address plus two words
        br_off    = {2'b00, b_target_q} - ({2'b00, mem_addr} + OFF_W'(2));
        imm24     = {{(24-OFF_W){br_off[OFF_W-1]}}, br_off};
        case (op_q)
            2'b00: begin
                case (cmd)
                    4'b0100, 4'b0010, 4'b0001, 4'b1101: legal = 1'b1;
                    4'b1010: begin
`ifdef ENC_SBIT_FORCE_EN
                        legal        = 1'b1;
                        funct_enc[0] = 1'b1;
`else
                        legal        = funct_q[0];
`endif
                    end
                    default: legal = 1'b0;
                endcase
            end
            2'b01:   legal = funct_q[4] & ~funct_q[2] & ~funct_q[1];
            2'b10:   legal = 1'b1;
            default: legal = 1'b0;
        endcase
        if (op_q == 2'b10) begin
            word = {cond_q, 4'b1010, imm24};
        end else begin
            word = {cond_q, op_q, funct_enc, rn_q, rd_q, src2_q};
        end
    end

    // Strobes follow the state but are suppressed by a same-cycle reset or clear
    always_comb begin
        mem_we = (state == S_WRITE) & ~reset & ~clear;
        err    = (state == S_ENCODE) & ~legal & ~reset & ~clear;
    end

    // Request capture, encode/write sequencing, address and error bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            req_ready  <= 1'b0;
            mem_addr   <= BASE;
            mem_wdata  <= 32'd0;
            err_cnt    <= 8'd0;
            full       <= 1'b0;
            op_q       <= 2'd0;
            funct_q    <= 6'd0;
            cond_q     <= 4'd0;
            rn_q       <= 4'd0;
            rd_q       <= 4'd0;
            src2_q     <= 12'd0;
            b_target_q <= '0;
        end else if (clear) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            mem_addr  <= BASE;
            err_cnt   <= 8'd0;
            full      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q       <= op;
                        funct_q    <= funct;
                        cond_q     <= cond;
                        rn_q       <= rn;
                        rd_q       <= rd;
                        src2_q     <= src2;
                        b_target_q <= b_target;
                        req_ready  <= 1'b0;
                        state      <= S_ENCODE;
                    end else begin
                        req_ready <= ~full;
                    end
                end
                S_ENCODE: begin
                    if (legal) begin
                        mem_wdata <= word;
                        state     <= S_WRITE;
                    end else begin
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        req_ready <= ~full;
                        state     <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    // Address wraps naturally; full holds off acceptance until clear
                    mem_addr  <= mem_addr + 1'b1;
                    if (mem_addr == LAST) begin
                        full <= 1'b1;
                    end
                    req_ready <= ~(full | (mem_addr == LAST));
                    state     <= S_IDLE;
                end
                default: begin
                    req_ready <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule
